// File: rtl/fp16_accum_pkg.sv
// rtl/fp16_accum_pkg.sv - shared FP16 constants and accumulator state encoding
package fp16_accum_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam int          EXP_BIAS  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude bits all clear: the value is +0 or -0.
    function automatic logic is_zero(input logic [15:0] h);
        return h[14:0] == 15'd0;
    endfunction

    // Same magnitude, opposite sign: the pair sums to exactly zero.
    function automatic logic cancels(input logic [15:0] a, input logic [15:0] b);
        return (a[14:0] == b[14:0]) && (a[15] != b[15]);
    endfunction

endpackage

// File: rtl/fp16_accum.sv
// rtl/fp16_accum.sv - sequential FP16 summation around an external combinational adder
module fp16_accum
    import fp16_accum_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_sum,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign add_a     = acc;
    assign add_b     = in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= FP16_ZERO;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= FP16_ZERO;
                        cnt <= '0;
                        if (len != '0) begin
                            len_q <= len;
                            state <= ACC;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        cnt <= cnt + LEN_W'(1);
                        // The adder cannot take a zero operand, so the first term is loaded as-is.
                        if (cnt == '0) begin
                            acc <= in_data;
                        end else if (is_zero(in_data)) begin
                            acc <= acc;
                        end else if (cancels(acc, in_data)) begin
                            acc <= FP16_ZERO;
                        end else begin
                            acc <= add_sum;
                        end
                        if (cnt == len_q - LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accum.sv
// tb/tb_fp16_accum.sv - directed self-checking bench for fp16_accum with a real-valued reference adder
module tb_fp16_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected view of the block: 0 idle, 1 accumulating, 2 result presented.
    int          exp_phase = 0;
    logic [15:0] exp_acc   = 16'h0000;
    int          terms_seen = 0;
    int          terms_want = 0;
    logic        checking  = 1'b0;

    always #5 clk = ~clk;

    fp16_accum #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    function automatic real fp16_to_real(input logic [15:0] h);
        real mag;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) mag = real'(h[9:0]) * (2.0 ** -24);
        else        mag = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real r);
        logic s;
        real  m;
        int   e;
        int   f;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (f == 1024) begin f = 0; e++; end
        return {s, e[4:0], f[9:0]};
    endfunction

    always_comb add_sum = real_to_fp16(fp16_to_real(add_a) + fp16_to_real(add_b));

    // Next running sum after one more term, following the block's summation rules.
    function automatic logic [15:0] model_step(input logic [15:0] sum, input logic [15:0] t, input logic first);
        if (first) return t;
        if (fp16_to_real(t) == 0.0) return sum;
        if (fp16_to_real(t) == -fp16_to_real(sum)) return 16'h0000;
        return real_to_fp16(fp16_to_real(sum) + fp16_to_real(t));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("busy",      16'(busy),      16'(exp_phase != 0));
            chk("in_ready",  16'(in_ready),  16'(exp_phase == 1));
            chk("out_valid", 16'(out_valid), 16'(exp_phase == 2));
            chk("add_a",     add_a,          exp_acc);
            chk("add_b",     add_b,          in_data);
            if (exp_phase == 2) chk("out_data", out_data, exp_acc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'($urandom_range(1, 200));
        exp_acc    = 16'h0000;
        terms_seen = 0;
        terms_want = n;
        exp_phase  = (n == 0) ? 2 : 1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        exp_acc = model_step(exp_acc, d, terms_seen == 0);
        terms_seen++;
        if (terms_seen == terms_want) exp_phase = 2;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_data = 16'($urandom);
            tick();
        end
    endtask

    task automatic drain(input logic with_start);
        out_ready = 1'b1;
        start     = with_start;
        len       = 8'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        exp_phase = 0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy",      16'(busy),      16'h0000);
        chk("reset_in_ready",  16'(in_ready),  16'h0000);
        chk("reset_out_valid", 16'(out_valid), 16'h0000);
        chk("reset_out_data",  out_data,       16'h0000);
        checking = 1'b1;
        tick();

        // 1.0 + 2.0 + 0.5 back-to-back
        do_start(3);
        send(16'h3C00);
        send(16'h4000);
        send(16'h3800);
        chk("model_sum_3p5", exp_acc, 16'h4300);
        chk("sum_3p5", out_data, 16'h4300);
        tick();
        drain(1'b0);
        gap(2);

        // Zero-length job goes straight to a zero result
        do_start(0);
        chk("len0_out_valid", 16'(out_valid), 16'h0001);
        chk("len0_out_data", out_data, 16'h0000);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        gap(2);
        in_valid = 1'b0;
        drain(1'b0);
        gap(1);

        // Exact cancellation
        do_start(2);
        send(16'h4000);
        send(16'hC000);
        chk("model_cancel", exp_acc, 16'h0000);
        chk("cancel", out_data, 16'h0000);
        drain(1'b0);

        // Gapped input, slow consumer, then a zero term leaves the sum alone
        do_start(3);
        send(16'h3E00);
        gap(3);
        send(16'h8000);
        gap(3);
        send(16'h3800);
        chk("model_gapped", exp_acc, 16'h4000);
        gap(5);
        chk("held_out_data", out_data, 16'h4000);
        drain(1'b0);

        // Reset mid-accumulation discards the partial sum
        do_start(4);
        send(16'h3C00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_phase = 0;
        exp_acc   = 16'h0000;
        chk("rst_mid_busy", 16'(busy), 16'h0000);
        chk("rst_mid_acc",  add_a,     16'h0000);
        do_start(1);
        send(16'h3C00);
        chk("after_rst", out_data, 16'h3C00);
        drain(1'b0);

        // start in ACC is ignored; start during the DONE handoff is ignored too
        do_start(3);
        send(16'h3C00);
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        send(16'h3C00);
        send(16'h3C00);
        chk("ignored_start", out_data, 16'h4200);
        drain(1'b1);
        gap(3);

        // Reset while the result awaits the consumer
        do_start(1);
        send(16'hBC00);
        gap(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_phase = 0;
        exp_acc   = 16'h0000;
        gap(2);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
